// File: rtl/mips32_mem_arbiter.sv
// Shares one fixed-latency single-port memory between the instruction-fetch and data ports.
// Data has priority; a starvation counter forces a fetch win after MAX_STARVE consecutive losses.
module mips32_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  // state | meaning
  // IDLE  | waiting for a request, arbitrates when one is present
  // ISSUE | one-cycle memory strobe, grant pulse to the winner
  // WAIT  | latency countdown until mem_rdata is valid
  // DONE  | one-cycle rvalid pulse to the winner
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] lat_cnt;
  logic [STV_W-1:0] starve_cnt;
  logic             we_lat;
  logic             data_win;

  // Data wins whenever it asks, unless fetch is also asking and has starved long enough.
  assign data_win = d_req && !(if_req && (starve_cnt == STV_W'(MAX_STARVE)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      we_lat     <= 1'b0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_gnt      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            if (data_win) begin
              owner     <= 1'b1;
              d_gnt     <= 1'b1;
              we_lat    <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (if_req && (starve_cnt != STV_W'(MAX_STARVE)))
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
              owner      <= 1'b0;
              if_gnt     <= 1'b1;
              we_lat     <= 1'b0;
              mem_addr   <= if_addr;
              starve_cnt <= '0;
            end
            mem_en <= 1'b1;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt <= CNT_W'(MEM_LAT);
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == CNT_W'(1)) begin
            if (owner) begin
              d_rvalid <= 1'b1;
              d_rdata  <= we_lat ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mips32_mem_arbiter.md
Name: mips32_mem_arbiter

Overview:
- Shares one single-port 1024x32 memory between the pipeline's instruction-fetch port and its data (LW/SW) port.
- Issues one access at a time to a fixed-latency memory and returns read data or write completion to the winning requester.
- Data port has priority; a starvation counter guarantees fetch progress.
- Sits between the pipeline stages and the memory array; single clock domain.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en sample to mem_rdata valid (>=1)
MAX_STARVE, 4, consecutive fetch-losing arbitrations before fetch is forced to win (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched instruction word
d_req  in  1  data request; held until d_gnt
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: load data valid / store complete
d_rdata  out  DATA_W  load data (0 for stores)
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable (valid with mem_en)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  transaction outstanding
owner  out  1  0=fetch, 1=data; owner of current/last transaction

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; starve counter 0; any outstanding transaction is discarded, with no rvalid ever issued for it.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if either request is present, arbitrate:
  - Only one request present: that requester wins.
  - Both present: data wins unless starve counter == MAX_STARVE, in which case fetch wins.
  - Winner's address, write enable and write data are latched; next state ISSUE.
- ISSUE (1 cycle): mem_en=1, mem_we=latched we (0 for fetch), mem_addr/mem_wdata from latch.
  - Winner's gnt=1 this cycle only; busy=1; owner=winner.
  - Latency counter loaded with MEM_LAT; next state WAIT.
- WAIT: counter decrements each cycle. At counter==1, the next edge captures mem_rdata (load/fetch) and enters DONE.
- DONE (1 cycle):
  - Winner's rvalid=1; rdata=captured word (d_rdata=0 for stores).
  - busy=0; next state IDLE.
- Latency: request seen in IDLE cycle T -> gnt/mem_en in T+1 -> rvalid in T+MEM_LAT+2. Back-to-back access period is MEM_LAT+3 cycles.
- Starve counter:
  - Increments (saturating at MAX_STARVE) on each arbitration where if_req=1 and data wins.
  - Clears when fetch wins.
  - Unchanged when if_req=0.
- Requests are only sampled in IDLE. Request or address changes during ISSUE/WAIT/DONE are ignored.
- rdata outputs hold their value until the next rvalid for that port. gnt and rvalid are never asserted to both ports in the same cycle.
- mem_we=0 and mem_wdata held whenever mem_en=0.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1 with if_addr=5 at cycle 0, memory word 5 = 32'h28020001 -> if_gnt and mem_en high at cycle 1 with mem_addr=5; if_rvalid high at cycle 4 with if_rdata=32'h28020001; busy low at cycle 4.
- Store then load: d_req with d_we=1, d_addr=198, d_wdata=5040 -> mem_we=1 at issue, d_rvalid with d_rdata=0. Then a load from 198 -> d_rdata=5040.
- Contention: if_req and d_req held continuously, MAX_STARVE=4 -> grant order D,D,D,D,F,D,D,D,D,F. No cycle asserts both gnts.
- Priority: both requests raised in the same IDLE cycle with starve counter 0 -> d_gnt, not if_gnt; the starve counter reads 1 afterwards.
- Reset mid-op: drop rst_n during WAIT of a fetch -> all outputs 0 immediately; after release no if_rvalid appears. A new if_req completes normally with full latency.
- Ignore-while-busy: change d_addr from 10 to 20 during WAIT -> mem_addr remains 10; the d_rdata returned is from address 10.
